dense_feeder: RTL and testbench
===============================

# dense_feeder

Sequencer that drives a dense layer from the producer side. It streams one activation per step, fetches the matching packed weight row from weight memory, and drives the per-lane value/weight/enable/accumulate controls. It captures the finished accumulators and hands them off on a valid/ready result port. It sits between the activation stream plus weight RAM and the dense layer's MAC array.

## Interface
- `N`, 16, element width in bits (signed).
- `Lanes`, 4, number of MAC engines driven in parallel.
- `AddrW`, 12, weight memory address width.
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  start a pass; sampled only in IDLE.
- `len_i`  in  AddrW  number of input activations K; sampled with `start_i`.
- `base_i`  in  AddrW  weight row base address; sampled with `start_i`.
- `busy_o`  out  1  high in any state other than IDLE.
- `done_o`  out  1  one-cycle pulse when a pass completes.
- `act_i`  in  N  activation stream data.
- `act_valid_i`  in  1  activation valid.
- `act_ready_o`  out  1  activation accepted when valid and ready are both high.
- `wmem_req_o`  out  1  weight read strobe.
- `wmem_addr_o`  out  AddrW  weight read address.
- `wmem_data_i`  in  Lanes*N  packed weight row; lane i is bits [i*N +: N]. Valid exactly 1 cycle after `wmem_req_o`.
- `en_o`  out  1  MAC enable to the dense layer.
- `accumulate_o`  out  1  0 on the first step of a pass (clear), 1 otherwise.
- `value_o`  out  Lanes*N  activation replicated to every lane.
- `weight_o`  out  Lanes*N  weight row forwarded to the lanes.
- `dense_i`  in  Lanes*N  dense layer outputs; valid 1 cycle after the last `en_o`.
- `res_o`  out  Lanes*N  captured result.
- `res_valid_o`  out  1  result valid.
- `res_ready_i`  in  1  result consumer ready.

## Operation
- States: IDLE, RUN, DRAIN, OUT.
- IDLE -> RUN on `start_i` with `len_i` != 0. This latches K, base, and step counter k=0.
- IDLE with `start_i` and `len_i` == 0: stay in IDLE and pulse `done_o` the next cycle. No result is produced and no memory read is issued.
- RUN, stage A:
  - `act_ready_o` = 1 while k < K.
  - On each handshake: register `act_i`, assert `wmem_req_o` with `wmem_addr_o` = base + k (modulo 2^AddrW, wrap allowed), then increment k.
- RUN, stage B (the cycle after a stage-A fire):
  - `en_o` = 1.
  - `value_o` = registered activation, replicated to all lanes.
  - `weight_o` = `wmem_data_i`.
  - `accumulate_o` = 0 for step 0, 1 for later steps.
- Back-to-back handshakes give one step per cycle. Gaps in `act_valid_i` give `en_o` = 0 bubbles. `accumulate_o` keeps its value during bubbles and is don't-care there.
- RUN -> DRAIN in the cycle stage B fires for step K-1.
- DRAIN lasts exactly 1 cycle. At its end, `dense_i` is latched into `res_o` and the state goes to OUT.
- OUT: `res_valid_o` = 1, and `res_o` is held stable until `res_ready_i`. On the handshake: go to IDLE and pulse `done_o` in that same cycle.
- `start_i` outside IDLE is ignored.
- Arithmetic: the only adder is the address adder, AddrW bits wide, with wrap. The step counter is AddrW+1 bits so that K = 2^AddrW−1 is handled.
- Reset values:
  - State = IDLE.
  - `busy_o`, `done_o`, `act_ready_o`, `wmem_req_o`, `en_o`, `accumulate_o`, `res_valid_o` = 0.
  - `wmem_addr_o`, `value_o`, `weight_o`, `res_o` = 0.
- Reset asserted mid-pass aborts the pass immediately. No `done_o` pulse is produced and no partial result is ever emitted.

## Timing
- Step k handshake at cycle t gives `wmem_req_o` at t (combinational from the handshake, with a registered address) and `en_o` at t+1.
- Last `en_o` at cycle T gives DRAIN at T+1, and `res_valid_o` high from T+2.
- Minimum pass latency from `start_i` with a continuously valid stream: K+3 cycles to `res_valid_o`.
- `act_ready_o` drops in the cycle after the K-th handshake. A stream beat offered past K is not consumed.

## Structure
- Shared package `dense_pkg`:
  - `feeder_state_e` enum (IDLE, RUN, DRAIN, OUT).
  - `DENSE_MAC_LATENCY` = 1. The DRAIN length is derived from this constant.
- One natural sub-module, `dense_step_pipe`: the stage-A/stage-B register pair (activation, first-step flag, valid) feeding `en_o`, `accumulate_o`, and `value_o`.

## Test plan
- Reset, then K=3, base=0x010, activations 1,2,3 back-to-back. Required: `wmem_addr_o` = 0x010, 0x011, 0x012; `en_o` high for 3 consecutive cycles; `accumulate_o` = 0,1,1; `res_valid_o` 2 cycles after the last `en_o`.
- K=4 with `act_valid_i` deasserted for 2 cycles between steps 1 and 2. Required: `en_o` bubbles of exactly 2 cycles; 4 enabled steps total; `accumulate_o` = 0 only on the first.
- Hold `res_ready_i` = 0 for 5 cycles in OUT while `dense_i` changes. Required: `res_o` stable; `done_o` pulses only on the handshake cycle.
- base=0xFFF, K=2. Required: addresses 0xFFF then 0x000.
- `start_i` with `len_i`=0. Required: `done_o` pulse; no `wmem_req_o`, `en_o`, or `res_valid_o`. A second `start_i` during RUN is ignored.
- `rst_ni` asserted mid-RUN after step 1. Required: all outputs go to 0 asynchronously; no `done_o`; a new pass afterwards starts with `accumulate_o` = 0.

Source files
------------

// File: rtl/dense_pkg.sv
// dense_pkg: types and constants shared by the dense-layer feeder blocks.
package dense_pkg;

    localparam int DENSE_N           = 16;
    localparam int DENSE_LANES       = 4;
    localparam int DENSE_ADDR_W      = 12;
    localparam int DENSE_MAC_LATENCY = 1;
    localparam int DRAIN_CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        OUT
    } feeder_state_e;

    // DRAIN counts down from this value to zero, so its length tracks the MAC latency.
    function automatic logic [DRAIN_CNT_W-1:0] drain_preset();
        return DRAIN_CNT_W'(DENSE_MAC_LATENCY - 1);
    endfunction

endpackage

// File: rtl/dense_feeder_if.sv
// dense_feeder_if: activation stream, weight memory, MAC array and result
// port bundled together. The feeder is the slave side.
interface dense_feeder_if
    import dense_pkg::*;
#(
    parameter int N     = DENSE_N,
    parameter int Lanes = DENSE_LANES,
    parameter int AddrW = DENSE_ADDR_W
);

    logic [N-1:0]       act_i;
    logic               act_valid_i;
    logic               act_ready_o;
    logic               wmem_req_o;
    logic [AddrW-1:0]   wmem_addr_o;
    logic [Lanes*N-1:0] wmem_data_i;
    logic               en_o;
    logic               accumulate_o;
    logic [Lanes*N-1:0] value_o;
    logic [Lanes*N-1:0] weight_o;
    logic [Lanes*N-1:0] dense_i;
    logic [Lanes*N-1:0] res_o;
    logic               res_valid_o;
    logic               res_ready_i;

    modport slave (
        input  act_i, act_valid_i, wmem_data_i, dense_i, res_ready_i,
        output act_ready_o, wmem_req_o, wmem_addr_o, en_o, accumulate_o,
               value_o, weight_o, res_o, res_valid_o
    );

    modport master (
        output act_i, act_valid_i, wmem_data_i, dense_i, res_ready_i,
        input  act_ready_o, wmem_req_o, wmem_addr_o, en_o, accumulate_o,
               value_o, weight_o, res_o, res_valid_o
    );

endinterface

// File: rtl/dense_step_pipe.sv
// dense_step_pipe: stage-A to stage-B register pair. Holds the accepted
// activation while its weight row is read, and produces the MAC enable and
// the accumulate/clear control for that step.
module dense_step_pipe
    import dense_pkg::*;
#(
    parameter int N = DENSE_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         fire,
    input  logic [N-1:0] act,
    input  logic         first_step,
    output logic         step_valid,
    output logic         accumulate,
    output logic [N-1:0] act_hold
);

    // Capture each handshake; valid lasts one cycle while data and accumulate hold through bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_valid <= 1'b0;
            accumulate <= 1'b0;
            act_hold   <= '0;
        end else begin
            step_valid <= fire;
            if (fire) begin
                act_hold   <= act;
                accumulate <= ~first_step;
            end
        end
    end

endmodule

// File: rtl/dense_feeder.sv
// dense_feeder: streams K activations into the dense layer, one weight row
// per step, then captures the accumulators and offers them on a valid/ready
// result port.
module dense_feeder
    import dense_pkg::*;
#(
    parameter int N     = DENSE_N,
    parameter int Lanes = DENSE_LANES,
    parameter int AddrW = DENSE_ADDR_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [AddrW-1:0] len_i,
    input  logic [AddrW-1:0] base_i,
    output logic             busy_o,
    output logic             done_o,
    dense_feeder_if.slave    bus
);

    feeder_state_e          state;
    logic [AddrW-1:0]       len_q;
    logic [AddrW-1:0]       addr_q;
    logic [AddrW:0]         k_q;
    logic                   ready_q;
    logic                   res_valid_q;
    logic                   done_zero_q;
    logic [DRAIN_CNT_W-1:0] drain_cnt;
    logic [Lanes*N-1:0]     res_q;

    logic                   fire;
    logic                   last_step_b;
    logic                   step_valid;
    logic                   step_accumulate;
    logic [N-1:0]           act_hold;

    assign fire        = bus.act_valid_i & ready_q;
    assign last_step_b = step_valid & (k_q == {1'b0, len_q});

    dense_step_pipe #(
        .N(N)
    ) u_step_pipe (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .fire       (fire),
        .act        (bus.act_i),
        .first_step (k_q == '0),
        .step_valid (step_valid),
        .accumulate (step_accumulate),
        .act_hold   (act_hold)
    );

    assign bus.act_ready_o  = ready_q;
    assign bus.wmem_req_o   = fire;
    assign bus.wmem_addr_o  = addr_q;
    assign bus.en_o         = step_valid;
    assign bus.accumulate_o = step_accumulate;
    assign bus.value_o      = {Lanes{act_hold}};
    assign bus.weight_o     = step_valid ? bus.wmem_data_i : '0;
    assign bus.res_o        = res_q;
    assign bus.res_valid_o  = res_valid_q;
    assign busy_o           = (state != IDLE);
    assign done_o           = done_zero_q | (res_valid_q & bus.res_ready_i);

    // Pass sequencer: latches the job, walks the weight rows, waits out the MAC latency and holds the result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            len_q       <= '0;
            addr_q      <= '0;
            k_q         <= '0;
            ready_q     <= 1'b0;
            res_valid_q <= 1'b0;
            done_zero_q <= 1'b0;
            drain_cnt   <= '0;
            res_q       <= '0;
        end else begin
            done_zero_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (len_i == '0) begin
                            done_zero_q <= 1'b1;
                        end else begin
                            state   <= RUN;
                            len_q   <= len_i;
                            addr_q  <= base_i;
                            k_q     <= '0;
                            ready_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (fire) begin
                        addr_q  <= addr_q + 1'b1;
                        k_q     <= k_q + 1'b1;
                        ready_q <= ((k_q + 1'b1) < {1'b0, len_q});
                    end
                    if (last_step_b) begin
                        state     <= DRAIN;
                        drain_cnt <= drain_preset();
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        res_q       <= bus.dense_i;
                        res_valid_q <= 1'b1;
                        state       <= OUT;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                OUT: begin
                    if (bus.res_ready_i) begin
                        res_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dense_feeder.sv
// tb_dense_feeder: table-driven passes through dense_feeder with a weight
// memory model, a MAC-array model and a scoreboard of expected steps/results.
module tb_dense_feeder;

    localparam int N     = 16;
    localparam int Lanes = 4;
    localparam int AddrW = 12;

    typedef struct packed {
        logic [63:0] value;
        logic [63:0] weight;
        logic        acc;
    } step_t;

    typedef struct {
        logic [11:0] base;
        int          k;
        logic [15:0] act [4];
        int          gap_at;
        int          gap_len;
        int          hold;
        bit          poke;
        logic [11:0] exp_last_addr;
        int          exp_en;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [AddrW-1:0] len;
    logic [AddrW-1:0] base;
    logic             busy;
    logic             done;

    logic [63:0]      dense_acc;
    logic [63:0]      dense_noise;

    int               errors;
    int               checks;
    int               cyc;

    logic [11:0]      addr_exp_q [$];
    step_t            step_exp_q [$];
    logic [63:0]      res_exp_q  [$];

    int               req_cnt;
    int               en_cnt;
    int               first_en;
    int               last_en;
    int               first_valid;
    int               valid_seen;
    int               done_cnt;
    int               done_bad;
    logic [11:0]      last_addr;
    bit               len0_window;

    vec_t             vecs [4];

    dense_feeder_if #(.N(N), .Lanes(Lanes), .AddrW(AddrW)) bus_if ();

    dense_feeder #(.N(N), .Lanes(Lanes), .AddrW(AddrW)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .len_i   (len),
        .base_i  (base),
        .busy_o  (busy),
        .done_o  (done),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] wrow(input logic [11:0] a);
        logic [63:0] r;
        for (int l = 0; l < 4; l++) begin
            r[l*16 +: 16] = {a, l[1:0], 2'b01};
        end
        return r;
    endfunction

    function automatic logic [63:0] macStep(input logic [63:0] acc, input logic [63:0] v,
                                            input logic [63:0] w, input logic accum);
        logic [63:0] r;
        logic [15:0] p;
        for (int l = 0; l < 4; l++) begin
            p = v[l*16 +: 16] * w[l*16 +: 16];
            r[l*16 +: 16] = (accum ? acc[l*16 +: 16] : 16'd0) + p;
        end
        return r;
    endfunction

    // Weight RAM: row data appears one cycle after the read strobe.
    always @(posedge clk) begin
        if (bus_if.wmem_req_o) bus_if.wmem_data_i <= wrow(bus_if.wmem_addr_o);
    end

    // MAC array: per-lane 16-bit accumulate, output valid one cycle after en.
    always @(posedge clk) begin
        if (bus_if.en_o) dense_acc <= macStep(dense_acc, bus_if.value_o, bus_if.weight_o, bus_if.accumulate_o);
    end

    assign bus_if.dense_i = dense_acc ^ dense_noise;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetStats();
        req_cnt     = 0;
        en_cnt      = 0;
        first_en    = -1;
        last_en     = -1;
        first_valid = -1;
        valid_seen  = 0;
        done_cnt    = 0;
        done_bad    = 0;
        last_addr   = '0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"},       64'(busy), 0);
        checkOutput({tag, "_done"},       64'(done), 0);
        checkOutput({tag, "_act_ready"},  64'(bus_if.act_ready_o), 0);
        checkOutput({tag, "_wmem_req"},   64'(bus_if.wmem_req_o), 0);
        checkOutput({tag, "_en"},         64'(bus_if.en_o), 0);
        checkOutput({tag, "_accumulate"}, 64'(bus_if.accumulate_o), 0);
        checkOutput({tag, "_res_valid"},  64'(bus_if.res_valid_o), 0);
        checkOutput({tag, "_wmem_addr"},  64'(bus_if.wmem_addr_o), 0);
        checkOutput({tag, "_value"},      bus_if.value_o, 0);
        checkOutput({tag, "_weight"},     bus_if.weight_o, 0);
        checkOutput({tag, "_res"},        bus_if.res_o, 0);
    endtask

    task automatic waitHandshake(output bit got);
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            got = bus_if.act_ready_o;
            tick();
            if (got) break;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [11:0] a;
        logic [63:0] w;
        logic [63:0] exp_res;
        logic [15:0] lane_prod;
        int          start_cyc;
        bit          got;
        exp_res = '0;
        resetStats();
        start     = 1'b1;
        len       = 12'(v.k);
        base      = v.base;
        start_cyc = cyc;
        tick();
        start = 1'b0;
        for (int s = 0; s < v.k; s++) begin
            if (s == v.gap_at) begin
                bus_if.act_valid_i = 1'b0;
                for (int g = 0; g < v.gap_len; g++) begin
                    if (g == 0 && v.poke) begin
                        start = 1'b1;
                        len   = 12'd1;
                        base  = 12'h555;
                    end
                    tick();
                    start = 1'b0;
                end
            end
            a = v.base + 12'(s);
            w = wrow(a);
            addr_exp_q.push_back(a);
            step_exp_q.push_back('{value: {4{v.act[s]}}, weight: w, acc: (s != 0)});
            for (int l = 0; l < 4; l++) begin
                lane_prod = v.act[s] * w[l*16 +: 16];
                exp_res[l*16 +: 16] = exp_res[l*16 +: 16] + lane_prod;
            end
            bus_if.act_i       = v.act[s];
            bus_if.act_valid_i = 1'b1;
            waitHandshake(got);
            if (!got) checkOutput("act_handshake_timeout", 0, 1);
        end
        bus_if.act_i = 16'h7777;
        @(negedge clk);
        checkOutput("past_k_ready", 64'(bus_if.act_ready_o), 0);
        tick();
        bus_if.act_valid_i = 1'b0;
        res_exp_q.push_back(exp_res);
        bus_if.res_ready_i = (v.hold == 0);
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus_if.res_valid_o) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        if (!got) checkOutput("res_valid_timeout", 0, 1);
        if (v.hold > 0) begin
            for (int h = 0; h < v.hold; h++) begin
                tick();
                dense_noise = {$urandom, $urandom};
                @(negedge clk);
                checkOutput("res_hold_stable", bus_if.res_o, exp_res);
                checkOutput("done_while_held", 64'(done), 0);
            end
            tick();
            bus_if.res_ready_i = 1'b1;
            @(negedge clk);
        end
        tick();
        bus_if.res_ready_i = 1'b0;
        dense_noise        = '0;
        @(negedge clk);
        checkOutput("idle_after_pass", 64'(busy), 0);
        tick();
        checkOutput("en_count", 64'(en_cnt), 64'(v.exp_en));
        checkOutput("last_addr", 64'(last_addr), 64'(v.exp_last_addr));
        checkOutput("bubble_cycles", 64'(last_en - first_en + 1 - en_cnt), 64'(v.gap_len));
        checkOutput("valid_after_last_en", 64'(first_valid - last_en), 2);
        if (v.gap_len == 0) checkOutput("pass_latency", 64'(first_valid - start_cyc), 64'(v.k + 3));
        checkOutput("done_count", 64'(done_cnt), 1);
        checkOutput("done_outside_handshake", 64'(done_bad), 0);
        checkOutput("steps_left", 64'(step_exp_q.size()), 0);
    endtask

    // Monitor: compares DUT outputs with the scoreboard on the falling edge.
    initial begin
        step_t st;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus_if.wmem_req_o) begin
                    req_cnt++;
                    last_addr = bus_if.wmem_addr_o;
                    if (addr_exp_q.size() == 0) checkOutput("unexpected_wmem_req", 1, 0);
                    else checkOutput("wmem_addr", 64'(bus_if.wmem_addr_o), 64'(addr_exp_q.pop_front()));
                end
                if (bus_if.en_o) begin
                    en_cnt++;
                    if (first_en < 0) first_en = cyc;
                    last_en = cyc;
                    if (step_exp_q.size() == 0) begin
                        checkOutput("unexpected_en", 1, 0);
                    end else begin
                        st = step_exp_q.pop_front();
                        checkOutput("value_o", bus_if.value_o, st.value);
                        checkOutput("weight_o", bus_if.weight_o, st.weight);
                        checkOutput("accumulate_o", 64'(bus_if.accumulate_o), 64'(st.acc));
                    end
                end
                if (bus_if.res_valid_o) begin
                    valid_seen++;
                    if (first_valid < 0) first_valid = cyc;
                end
                if (done) begin
                    done_cnt++;
                    if (!(bus_if.res_valid_o && bus_if.res_ready_i) && !len0_window) done_bad++;
                end
                if (bus_if.res_valid_o && bus_if.res_ready_i) begin
                    if (res_exp_q.size() == 0) checkOutput("unexpected_result", 1, 0);
                    else checkOutput("res_o", bus_if.res_o, res_exp_q.pop_front());
                    checkOutput("done_on_handshake", 64'(done), 1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit got;
        errors             = 0;
        checks             = 0;
        cyc                = 0;
        len0_window        = 1'b0;
        dense_noise        = '0;
        rst_n              = 1'b0;
        start              = 1'b0;
        len                = '0;
        base               = '0;
        bus_if.act_i       = '0;
        bus_if.act_valid_i = 1'b0;
        bus_if.res_ready_i = 1'b0;
        resetStats();

        vecs[0] = '{base: 12'h010, k: 3, act: '{16'd1, 16'd2, 16'd3, 16'd0},
                    gap_at: -1, gap_len: 0, hold: 0, poke: 1'b0, exp_last_addr: 12'h012, exp_en: 3};
        vecs[1] = '{base: 12'h100, k: 4, act: '{16'd5, -16'sd6, 16'd7, -16'sd8},
                    gap_at: 2, gap_len: 2, hold: 0, poke: 1'b1, exp_last_addr: 12'h103, exp_en: 4};
        vecs[2] = '{base: 12'h020, k: 2, act: '{16'd100, -16'sd100, 16'd0, 16'd0},
                    gap_at: -1, gap_len: 0, hold: 5, poke: 1'b0, exp_last_addr: 12'h021, exp_en: 2};
        vecs[3] = '{base: 12'hFFF, k: 2, act: '{16'd9, 16'd10, 16'd0, 16'd0},
                    gap_at: -1, gap_len: 0, hold: 0, poke: 1'b0, exp_last_addr: 12'h000, exp_en: 2};

        #2;
        checkAllZero("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 3; i++) begin
            $display("[TB] pass %0d: base=0x%0h K=%0d", i, vecs[i].base, vecs[i].k);
            applyStimulus(vecs[i]);
        end

        $display("[TB] zero-length start");
        resetStats();
        len0_window = 1'b1;
        start       = 1'b1;
        len         = '0;
        base        = 12'h0AB;
        @(negedge clk);
        checkOutput("len0_busy", 64'(busy), 0);
        checkOutput("len0_done_early", 64'(done), 0);
        tick();
        start = 1'b0;
        @(negedge clk);
        checkOutput("len0_done", 64'(done), 1);
        for (int n = 0; n < 3; n++) begin
            tick();
            @(negedge clk);
        end
        tick();
        checkOutput("len0_done_count", 64'(done_cnt), 1);
        checkOutput("len0_wmem_req", 64'(req_cnt), 0);
        checkOutput("len0_en", 64'(en_cnt), 0);
        checkOutput("len0_res_valid", 64'(valid_seen), 0);
        len0_window = 1'b0;

        $display("[TB] reset during RUN");
        resetStats();
        start = 1'b1;
        len   = 12'd4;
        base  = 12'h200;
        tick();
        start = 1'b0;
        for (int s = 0; s < 2; s++) begin
            addr_exp_q.push_back(12'h200 + 12'(s));
            step_exp_q.push_back('{value: {4{16'(11 + s)}}, weight: wrow(12'h200 + 12'(s)), acc: (s != 0)});
            bus_if.act_i       = 16'(11 + s);
            bus_if.act_valid_i = 1'b1;
            waitHandshake(got);
            if (!got) checkOutput("rst_handshake_timeout", 0, 1);
        end
        bus_if.act_valid_i = 1'b0;
        checkOutput("pre_reset_en", 64'(bus_if.en_o), 1);
        checkOutput("pre_reset_accumulate", 64'(bus_if.accumulate_o), 1);
        rst_n = 1'b0;
        #1;
        checkAllZero("mid_run_reset");
        tick();
        tick();
        addr_exp_q.delete();
        step_exp_q.delete();
        res_exp_q.delete();
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) tick();
        @(negedge clk);
        checkOutput("reset_no_done", 64'(done_cnt), 0);
        checkOutput("reset_no_result", 64'(valid_seen), 0);
        checkOutput("reset_idle", 64'(busy), 0);
        tick();

        $display("[TB] pass 3 after reset: base=0x%0h K=%0d", vecs[3].base, vecs[3].k);
        applyStimulus(vecs[3]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
